// File: rtl/hazard_if.sv
// ID-stage to hazard-scoreboard bundle.
// Handshake: the ID stage presents an instruction with issue_valid_id. It is
// accepted (issued) on a rising edge where issue_valid_id = 1, flush = 0 and
// stall = 0. stall acts as the not-ready signal and depends only on the
// current inputs and counters. flush drops the instruction without issuing it.
interface hazard_if;
  logic        issue_valid_id;
  logic        flush;
  logic [4:0]  rs1_addr_id;
  logic [4:0]  rs2_addr_id;
  logic        rs1_used_id;
  logic        rs2_used_id;
  logic [4:0]  rd_addr_id;
  logic        ctrl_reg_we_id;
  logic [1:0]  lat_class_id;
  logic        stall;
  logic [31:0] busy_vec;
  logic [31:0] stall_count;

  modport master (
    output issue_valid_id, flush, rs1_addr_id, rs2_addr_id, rs1_used_id,
           rs2_used_id, rd_addr_id, ctrl_reg_we_id, lat_class_id,
    input  stall, busy_vec, stall_count
  );

  modport slave (
    input  issue_valid_id, flush, rs1_addr_id, rs2_addr_id, rs1_used_id,
           rs2_used_id, rd_addr_id, ctrl_reg_we_id, lat_class_id,
    output stall, busy_vec, stall_count
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Register hazard scoreboard. It keeps a 2-bit countdown for each register
// x1..x31. The countdown gives the cycles left before the in-flight result
// can be forwarded to ID. stall is raised for RAW and WAW hazards.
// Optional feature: define HAZARD_STATS_EN to enable the stall_count counter.
// Without it, stall_count reads as constant 0.
module hazard_scoreboard (
  input  logic     clk,
  input  logic     rst_n,
  hazard_if.slave  hz
);

  logic [1:0]  cnt_q [31:1];
  logic [1:0]  cnt_d [31:1];
  logic [1:0]  rs1_cnt;
  logic [1:0]  rs2_cnt;
  logic [1:0]  rd_cnt;
  logic [1:0]  bubbles;
  logic        raw_hit;
  logic        waw_hit;
  logic        stall_c;
  logic        issue;
  logic        load_en;
  logic [31:0] busy_q;
  logic [31:0] busy_d;

  // Read the countdowns of the ID operands. x0 has no storage, so it reads as 0.
  always_comb begin
    rs1_cnt = '0;
    rs2_cnt = '0;
    rd_cnt  = '0;
    for (int r = 1; r < 32; r++) begin
      if (hz.rs1_addr_id == 5'(r)) rs1_cnt = cnt_q[r];
      if (hz.rs2_addr_id == 5'(r)) rs2_cnt = cnt_q[r];
      if (hz.rd_addr_id  == 5'(r)) rd_cnt  = cnt_q[r];
    end
  end

  // Map the result class to bubble cycles. Class 3 behaves as long-latency.
  always_comb begin
    bubbles = 2'd3;
    case (hz.lat_class_id)
      2'd0:    bubbles = 2'd0;
      2'd1:    bubbles = 2'd1;
      default: bubbles = 2'd3;
    endcase
  end

  // Detect hazards against the pre-issue counters. This also covers a source
  // that equals the same instruction's rd.
  always_comb begin
    raw_hit = (hz.rs1_used_id && (hz.rs1_addr_id != 5'd0) && (rs1_cnt != 2'd0)) ||
              (hz.rs2_used_id && (hz.rs2_addr_id != 5'd0) && (rs2_cnt != 2'd0));
    waw_hit = hz.ctrl_reg_we_id && (hz.rd_addr_id != 5'd0) && (rd_cnt > bubbles);
    stall_c = hz.issue_valid_id && !hz.flush && (raw_hit || waw_hit);
    issue   = hz.issue_valid_id && !hz.flush && !stall_c;
    load_en = issue && hz.ctrl_reg_we_id && (hz.rd_addr_id != 5'd0);
  end

  // Compute next counters. An issuing write loads its rd and overrides the decrement.
  always_comb begin
    busy_d = '0;
    for (int r = 1; r < 32; r++) begin
      cnt_d[r] = (cnt_q[r] != 2'd0) ? cnt_q[r] - 2'd1 : 2'd0;
      if (load_en && (hz.rd_addr_id == 5'(r))) cnt_d[r] = bubbles;
      busy_d[r] = (cnt_d[r] != 2'd0);
    end
  end

  // Counter and busy registers. Reset discards all pending results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 1; r < 32; r++) cnt_q[r] <= '0;
      busy_q <= '0;
    end else begin
      for (int r = 1; r < 32; r++) cnt_q[r] <= cnt_d[r];
      busy_q <= busy_d;
    end
  end

  assign hz.stall    = stall_c;
  assign hz.busy_vec = busy_q;

`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cnt_q;

  // Count every edge that sees a stall. The counter wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_cnt_q <= '0;
    else if (stall_c) stall_cnt_q <= stall_cnt_q + 32'd1;
  end

  assign hz.stall_count = stall_cnt_q;
`else
  assign hz.stall_count = '0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard. The scenarios cover load-use,
// long-latency, x0/unused operands, WAW, flush, async reset and self-dependency.
module tb_hazard_scoreboard;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  hazard_if hz ();

  hazard_scoreboard dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hz)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic drive(input logic v, input logic fl, input logic [4:0] rs1,
                       input logic u1, input logic [4:0] rs2, input logic u2,
                       input logic [4:0] rd, input logic we, input logic [1:0] cls);
    hz.issue_valid_id = v;
    hz.flush          = fl;
    hz.rs1_addr_id    = rs1;
    hz.rs1_used_id    = u1;
    hz.rs2_addr_id    = rs2;
    hz.rs2_used_id    = u2;
    hz.rd_addr_id     = rd;
    hz.ctrl_reg_we_id = we;
    hz.lat_class_id   = cls;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 2'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold the current ID instruction and count stall cycles and the cycles
  // where busy_vec[idx] is set. Returns at a negedge where stall = 0.
  task automatic measure(input int idx, output int n_stall, output int n_busy);
    n_stall = 0;
    n_busy  = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (hz.busy_vec[idx]) n_busy++;
      if (!hz.stall) break;
      n_stall++;
      tick();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    #12;
    checks++;
    if (hz.busy_vec !== 32'd0) begin
      errors++; $display("FAIL reset_busy got %h expected 0", hz.busy_vec);
    end
    checks++;
    if (hz.stall_count !== 32'd0) begin
      errors++; $display("FAIL reset_stall_count got %0d expected 0", hz.stall_count);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive(1'b1, 1'b0, 5'd3, 1'b1, 5'd17, 1'b1, 5'd2, 1'b1, 2'd2);
    @(negedge clk);
    checks++;
    if (hz.stall !== 1'b0) begin
      errors++; $display("FAIL reset_first_stall got %b expected 0", hz.stall);
    end
    idle();
    tick();
  endtask

  task automatic test_load_use();
    int ns, nb;
    drive(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 2'd1);
    @(negedge clk);
    checks++;
    if (hz.stall !== 1'b0) begin
      errors++; $display("FAIL load_use_producer_stall got %b expected 0", hz.stall);
    end
    tick();
    drive(1'b1, 1'b0, 5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 2'd0);
    measure(5, ns, nb);
    checks++;
    if (ns !== 1) begin
      errors++; $display("FAIL load_use_stalls got %0d expected 1", ns);
    end
    checks++;
    if (nb !== 1) begin
      errors++; $display("FAIL load_use_busy_cycles got %0d expected 1", nb);
    end
    tick();
    idle();
    @(negedge clk);
    checks++;
    if (hz.busy_vec !== 32'd0) begin
      errors++; $display("FAIL load_use_busy_after got %h expected 0", hz.busy_vec);
    end
    tick();
  endtask

  task automatic test_long_op();
    int ns, nb;
    logic [31:0] sc0, exp_sc;
    drive(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 2'd2);
    @(negedge clk);
    sc0 = hz.stall_count;
    tick();
    drive(1'b1, 1'b0, 5'd7, 1'b1, 5'd7, 1'b1, 5'd8, 1'b1, 2'd0);
    measure(7, ns, nb);
    checks++;
    if (ns !== 3) begin
      errors++; $display("FAIL long_op_stalls got %0d expected 3", ns);
    end
`ifdef HAZARD_STATS_EN
    exp_sc = sc0 + 32'd3;
`else
    exp_sc = 32'd0;
`endif
    checks++;
    if (hz.stall_count !== exp_sc) begin
      errors++; $display("FAIL long_op_stall_count got %0d expected %0d", hz.stall_count, exp_sc);
    end
    tick();
    idle();
    tick();
  endtask

  task automatic test_x0_unused();
    drive(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 2'd1);
    tick();
    drive(1'b1, 1'b0, 5'd0, 1'b1, 5'd0, 1'b1, 5'd1, 1'b1, 2'd0);
    @(negedge clk);
    checks++;
    if (hz.stall !== 1'b0) begin
      errors++; $display("FAIL x0_stall got %b expected 0", hz.stall);
    end
    checks++;
    if (hz.busy_vec !== 32'd0) begin
      errors++; $display("FAIL x0_busy got %h expected 0", hz.busy_vec);
    end
    tick();
    drive(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 2'd1);
    tick();
    drive(1'b1, 1'b0, 5'd0, 1'b0, 5'd9, 1'b0, 5'd1, 1'b1, 2'd0);
    @(negedge clk);
    checks++;
    if (hz.stall !== 1'b0) begin
      errors++; $display("FAIL unused_rs2_stall got %b expected 0", hz.stall);
    end
    checks++;
    if (hz.busy_vec[9] !== 1'b1) begin
      errors++; $display("FAIL unused_rs2_busy9 got %b expected 1", hz.busy_vec[9]);
    end
    tick();
    idle();
    tick();
  endtask

  task automatic test_waw();
    int ns, nb;
    drive(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1, 2'd2);
    tick();
    drive(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1, 2'd1);
    measure(4, ns, nb);
    checks++;
    if (ns !== 2) begin
      errors++; $display("FAIL waw_load_stalls got %0d expected 2", ns);
    end
    tick();
    idle();
    tick();
    tick();
    drive(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1, 2'd2);
    tick();
    drive(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1, 2'd0);
    measure(4, ns, nb);
    checks++;
    if (ns !== 3) begin
      errors++; $display("FAIL waw_alu_stalls got %0d expected 3", ns);
    end
    tick();
    idle();
    tick();
    drive(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1, 2'd0);
    @(negedge clk);
    checks++;
    if (hz.stall !== 1'b0) begin
      errors++; $display("FAIL waw_alu_idle_stall got %b expected 0", hz.stall);
    end
    tick();
    idle();
    tick();
  endtask

  task automatic test_flush();
    drive(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 2'd1);
    tick();
    drive(1'b1, 1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd10, 1'b1, 2'd1);
    @(negedge clk);
    checks++;
    if (hz.stall !== 1'b0) begin
      errors++; $display("FAIL flush_stall got %b expected 0", hz.stall);
    end
    checks++;
    if (hz.busy_vec[3] !== 1'b1) begin
      errors++; $display("FAIL flush_busy3_during got %b expected 1", hz.busy_vec[3]);
    end
    tick();
    idle();
    @(negedge clk);
    checks++;
    if (hz.busy_vec !== 32'd0) begin
      errors++; $display("FAIL flush_busy_after got %h expected 0", hz.busy_vec);
    end
    tick();
  endtask

  task automatic test_self_dep();
    drive(1'b1, 1'b0, 5'd13, 1'b1, 5'd0, 1'b0, 5'd13, 1'b1, 2'd1);
    @(negedge clk);
    checks++;
    if (hz.stall !== 1'b0) begin
      errors++; $display("FAIL self_dep_stall got %b expected 0", hz.stall);
    end
    tick();
    idle();
    @(negedge clk);
    checks++;
    if (hz.busy_vec !== 32'h0000_2000) begin
      errors++; $display("FAIL self_dep_busy got %h expected 00002000", hz.busy_vec);
    end
    tick();
  endtask

  task automatic test_async_reset();
    drive(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd12, 1'b1, 2'd2);
    tick();
    drive(1'b1, 1'b0, 5'd12, 1'b1, 5'd0, 1'b0, 5'd14, 1'b1, 2'd0);
    @(negedge clk);
    checks++;
    if (hz.stall !== 1'b1) begin
      errors++; $display("FAIL areset_pre_stall got %b expected 1", hz.stall);
    end
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (hz.busy_vec !== 32'd0) begin
      errors++; $display("FAIL areset_busy got %h expected 0", hz.busy_vec);
    end
    checks++;
    if (hz.stall !== 1'b0) begin
      errors++; $display("FAIL areset_stall got %b expected 0", hz.stall);
    end
    checks++;
    if (hz.stall_count !== 32'd0) begin
      errors++; $display("FAIL areset_stall_count got %0d expected 0", hz.stall_count);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (hz.stall !== 1'b0) begin
      errors++; $display("FAIL areset_post_stall got %b expected 0", hz.stall);
    end
    tick();
    idle();
    tick();
  endtask

  // Sequence and final report
  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_load_use();
    test_long_op();
    test_x0_unused();
    test_waw();
    test_flush();
    test_self_dep();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 clk  input  1  rising-edge clock; sole clock of the block.
REQ-002 rst_n  input  1  asynchronous, active-low reset.
REQ-003 issue_valid_id  input  1  ID stage holds a valid instruction.
REQ-004 flush  input  1  kill the ID instruction this cycle; it is not issued.
REQ-005 rs1_addr_id / rs2_addr_id  input  5 each  ID source register addresses.
REQ-006 rs1_used_id / rs2_used_id  input  1 each  the corresponding source operand is actually read.
REQ-007 rd_addr_id  input  5  ID destination register.
REQ-008 ctrl_reg_we_id  input  1  the ID instruction writes rd.
REQ-009 lat_class_id  input  2  result class: 0 = ALU, 1 = load, 2 = long-latency, 3 = treated as 2.
REQ-010 stall  output  1  combinational; hold the PC/IF/ID registers and inject a bubble into EX.
REQ-011 busy_vec  output  32  registered; bit r = 1 when cnt[r] != 0; bit 0 is always 0.
REQ-012 stall_count  output  32  registered stall-cycle counter (see Configuration).

Function
REQ-013 The block SHALL hold one 2-bit countdown cnt[r] per register r in 1..31, giving the cycles remaining before r's result can be forwarded to an ID consumer; register 0 has no storage.
REQ-014 Bubble count per class SHALL be: ALU 0, load 1, long 3.
REQ-015 raw_hit SHALL be true when, for either source operand: used = 1, addr != 0, and cnt[addr] != 0.
REQ-016 waw_hit SHALL be true when ctrl_reg_we_id = 1, rd_addr_id != 0, and cnt[rd] > bubbles(lat_class_id).
REQ-017 stall SHALL equal issue_valid_id AND NOT flush AND (raw_hit OR waw_hit), with no register stage.
REQ-018 An issue occurs when issue_valid_id = 1, flush = 0, and stall = 0.
REQ-019 On an issue with ctrl_reg_we_id = 1 and rd != 0, cnt[rd] SHALL load bubbles(lat_class_id) at the next edge.
REQ-020 Every other non-zero cnt SHALL decrement by 1 per cycle, including cycles where stall = 1; counters at 0 SHALL stay at 0.
REQ-021 Load and decrement on the same rd in the same cycle: the load SHALL win.
REQ-022 An issue with rd = 0 or ctrl_reg_we_id = 0 SHALL change no counter.
REQ-023 A cycle with flush = 1 SHALL NOT load any counter; counters for already-issued instructions SHALL keep counting down.
REQ-024 The RAW check SHALL be independent of lat_class_id; a source equal to rd of the same instruction SHALL be checked against the pre-issue cnt.
REQ-025 The module SHALL NOT perform forwarding selection; an ALU-class producer leaves cnt at 0, so no stall is raised for it.

Reset
REQ-026 While rst_n = 0, all cnt, busy_vec and stall_count SHALL be 0 immediately (asynchronously), independent of clk.
REQ-027 stall SHALL be 0 whenever every cnt = 0 and waw_hit = 0, including the first cycle after reset release.
REQ-028 Reset asserted mid-countdown SHALL discard all pending entries; no stall SHALL resume after release.

Configuration
REQ-029 Macro HAZARD_STATS_EN SHALL control stall_count.
REQ-030 With HAZARD_STATS_EN defined: stall_count SHALL increment by 1 on every edge where stall = 1, wrapping modulo 2^32.
REQ-031 Without HAZARD_STATS_EN: stall_count SHALL be constant 0 with no counter flops; all other behaviour SHALL be identical.

Verification
REQ-032 Load-use: issue lw x5 (class 1); next cycle add x6, x5, x1 with rs1_used = 1 -> stall = 1 for exactly 1 cycle; the add then issues; busy_vec[5] = 1 for 1 cycle only.
REQ-033 Long op: issue mul x7 (class 2); dependent sub x8, x7, x7 next cycle -> stall = 1 for 3 consecutive cycles, then 0; with HAZARD_STATS_EN, stall_count = 3.
REQ-034 x0 and unused operands: lw x0; then add x1, x0, x0 -> no stall, busy_vec = 0. Also lw x9; then jal using rs2 = 9 with rs2_used = 0 -> no stall.
REQ-035 WAW: issue mul x4 (class 2); next cycle lw x4 (class 1) -> stall until cnt[4] <= 1 (2 stall cycles); an ALU write to x4 issued after the mul -> 0 stall cycles only once cnt[4] = 0.
REQ-036 Flush: lw x3 issued; next cycle dependent with flush = 1 -> stall = 0 and no counter loaded; cnt[3] still reaches 0 one cycle later.
REQ-037 Async reset: assert rst_n = 0 mid-cycle with cnt[12] = 3 -> busy_vec = 0 before the next clk edge; after release, a dependent on x12 -> no stall.
